// File: rtl/ram72_uart_tx.sv
// Serializes one 72-bit word as nine 8N1 UART frames, least significant byte first.
// Optional idle bit-times follow each stop bit.
module ram72_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] word_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        tx,
    output logic        busy_o,
    output logic [3:0]  byte_idx_o
);

    // state   | meaning
    // S_IDLE  | waiting for a word, line idle high
    // S_START | start bit (tx=0)
    // S_DATA  | eight data bits, LSB first
    // S_STOP  | stop bit (tx=1)
    // S_GAP   | GAP_BITS idle bit-times after the stop bit
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [3:0]        gap_q, gap_d;
    logic [3:0]        byte_idx_q, byte_idx_d;
    logic [71:0]       shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              baud_last;
    logic              byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        byte_done  = 1'b0;
        baud_last  = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                baud_d     = '0;
                bit_d      = '0;
                gap_d      = '0;
                byte_idx_d = '0;
                if (valid_i) begin
                    shreg_d = word_i;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    if (GAP_BITS > 0) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (baud_last) begin
                    if (gap_q == GAP_LAST) begin
                        byte_done = 1'b1;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (byte_done) begin
            if (byte_idx_q < 4'd8) begin
                byte_idx_d = byte_idx_q + 4'd1;
                shreg_d    = {8'h00, shreg_q[71:8]};
                state_d    = S_START;
            end else begin
                byte_idx_d = '0;
                state_d    = S_IDLE;
            end
        end

        // tx is the registered image of the level the next state will drive
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign ready_o    = (state_q == S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign tx         = tx_q;
    assign byte_idx_o = byte_idx_q;

endmodule
